// File: rtl/memory_access.sv
// M stage: one data-memory transaction per load/store over req/ack,
// load data formatting, forward taps and the M/W pipeline register.
module memory_access #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_data_pc4,
    input  logic [31:0] i_data_alures,
    input  logic [31:0] i_data_rt,
    input  logic [4:0]  i_addr_regdst,
    input  logic        i_con_Mmemread,
    input  logic        i_con_Mmemwrite,
    input  logic [1:0]  i_con_Wloadmux,
    input  logic        i_con_Walupc8,
    input  logic        i_con_Wmemtoreg,
    input  logic        i_con_Wregwrite,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    output logic        o_con_stall,
    output logic [31:0] o_data_FMalures,
    output logic [31:0] o_data_FMmemout,
    output logic [31:0] o_data_pc4,
    output logic [31:0] o_data_alures,
    output logic [31:0] o_data_memout,
    output logic [4:0]  o_addr_regdst,
    output logic        o_con_Walupc8,
    output logic        o_con_Wmemtoreg,
    output logic        o_con_Wregwrite,
    output logic        o_err_misalign,
    output logic        o_err_timeout
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        live_q;
    logic [31:0] pc4_q, alures_q, memout_q;
    logic [4:0]  regdst_q;
    logic        alupc8_q, memtoreg_q, regwrite_q;
    logic        err_mis_q, err_to_q;

    logic        memop, is_store, is_word, is_half;
    logic        misaligned, aligned_op, go;
    logic        timeout_hit, req, ack_eff, stall;
    logic [31:0] load_fmt, memout_d;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  lane;

    assign lane       = i_data_alures[1:0];
    assign memop      = i_con_Mmemread | i_con_Mmemwrite;
    assign is_store   = i_con_Mmemwrite;
    assign is_word    = (i_con_Wloadmux == 2'b00);
    assign is_half    = (i_con_Wloadmux == 2'b01);
    assign misaligned = memop & ((is_word & (|lane)) | (is_half & lane[0]));
    assign aligned_op = memop & ~misaligned;

    // live_q keeps the request low in the first cycle after reset
    assign go          = aligned_op & i_nrst & live_q;
    assign timeout_hit = (state_q == S_WAIT) & go & (cnt_q == TMO) & ~i_mem_ack;
    assign req         = go & ~timeout_hit;
    assign ack_eff     = req & i_mem_ack;
    assign stall       = i_nrst & aligned_op & ~ack_eff & ~timeout_hit;

    always_comb begin
        half_sel = lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (lane)
            2'd0:    byte_sel = i_mem_rdata[7:0];
            2'd1:    byte_sel = i_mem_rdata[15:8];
            2'd2:    byte_sel = i_mem_rdata[23:16];
            default: byte_sel = i_mem_rdata[31:24];
        endcase
        case (i_con_Wloadmux)
            2'b00:   load_fmt = i_mem_rdata;
            2'b01:   load_fmt = {{16{half_sel[15]}}, half_sel};
            2'b10:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
            default: load_fmt = {24'h0, byte_sel};
        endcase
    end

    always_comb begin
        be    = 4'b0000;
        wdata = i_data_rt;
        if (is_store) begin
            if (is_word) begin
                be = 4'b1111;
            end else if (is_half) begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_data_rt[15:0]}};
            end else begin
                be    = 4'b0001 << lane;
                wdata = {4{i_data_rt[7:0]}};
            end
        end
    end

    assign memout_d = (aligned_op & ~is_store & ~timeout_hit) ? load_fmt : 32'h0;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            live_q     <= 1'b0;
            pc4_q      <= 32'h0;
            alures_q   <= 32'h0;
            memout_q   <= 32'h0;
            regdst_q   <= 5'd0;
            alupc8_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            err_mis_q <= misaligned;
            if (timeout_hit) err_to_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (req && !i_mem_ack) begin
                        state_q <= S_WAIT;
                        cnt_q   <= 8'd1;
                    end
                end
                default: begin
                    if (!req || ack_eff) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
            // stall cycles insert a bubble; data registers hold
            if (stall) begin
                alupc8_q   <= 1'b0;
                memtoreg_q <= 1'b0;
                regwrite_q <= 1'b0;
            end else begin
                pc4_q      <= i_data_pc4;
                alures_q   <= i_data_alures;
                memout_q   <= memout_d;
                regdst_q   <= i_addr_regdst;
                alupc8_q   <= i_con_Walupc8;
                memtoreg_q <= i_con_Wmemtoreg;
                regwrite_q <= i_con_Wregwrite & ~misaligned;
            end
        end
    end

    assign o_mem_req       = req;
    assign o_mem_we        = req & is_store;
    assign o_mem_addr      = {i_data_alures[31:2], 2'b00};
    assign o_mem_wdata     = wdata;
    assign o_mem_be        = be;
    assign o_con_stall     = stall;
    assign o_data_FMalures = i_data_alures;
    assign o_data_FMmemout = load_fmt;
    assign o_data_pc4      = pc4_q;
    assign o_data_alures   = alures_q;
    assign o_data_memout   = memout_q;
    assign o_addr_regdst   = regdst_q;
    assign o_con_Walupc8   = alupc8_q;
    assign o_con_Wmemtoreg = memtoreg_q;
    assign o_con_Wregwrite = regwrite_q;
    assign o_err_misalign  = err_mis_q;
    assign o_err_timeout   = err_to_q;

endmodule
